mackerel_dtack_gen: RTL
=======================

// Module: mackerel_dtack_gen
// PURPOSE
//  Bus-cycle terminator downstream of the address decoder. Consumes AS, the decoder's active-low
//  chip enables and the MFP's own DTACK. Drives the 68000 DTACK with per-device wait states, or
//  BERR when no device answers within a timeout. Runs on the CPU clock (decoder's divided clock).
// PARAMETERS
//  ROM_WS    2   wait cycles inserted before DTACK for ROM accesses (0..15)
//  RAM_WS    0   wait cycles inserted before DTACK for RAM accesses (0..15)
//  TIMEOUT   64  cycles from cycle start to BERR if unterminated (2..255, > max WS+2)
//  TO_W      8   width of timeout counter; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  CLK        in   1  CPU clock; all state on rising edge
//  RST        in   1  async active-low reset
//  AS         in   1  68000 address strobe, active low
//  ROMEN      in   1  ROM select from decoder, active low (AS-qualified)
//  RAMEN0     in   1  RAM bank 0 select from decoder, active low (AS-qualified)
//  MFPEN      in   1  MFP select from decoder, active low (NOT AS-qualified; gated here)
//  MFP_DTACK  in   1  MC68901 DTACK, active low, asynchronous to CLK
//  DTACK      out  1  to CPU, active low, registered
//  BERR       out  1  to CPU, active low, registered
//  BUSY       out  1  high while FSM is not IDLE
// BEHAVIOUR
//  Reset (RST low, async): state=IDLE, DTACK=1, BERR=1, BUSY=0, counters=0, sync flops=1.
//  MFP_DTACK passes a 2-flop synchronizer (reset 1) before use; sync output = mdt_s.
//  States: IDLE, WAIT, MFPW, ACK, ERR.
//  IDLE: on edge with AS=0 select target, priority ROM > RAM > MFP > none:
//    ROMEN=0 -> WAIT, ws_cnt=ROM_WS;  RAMEN0=0 -> WAIT, ws_cnt=RAM_WS;
//    (MFPEN=0 & AS=0) -> MFPW;  none -> MFPW-like unmatched wait (state WAIT, ws_cnt
//    disabled, flag nomatch=1) terminating only via timeout. to_cnt cleared to 0 on entry.
//  WAIT (matched): ws_cnt!=0 -> decrement; ws_cnt==0 -> ACK, DTACK<=0 same edge.
//    Latency: AS sampled low at edge N -> DTACK low after edge N+1+WS.
//  MFPW: mdt_s==0 -> ACK, DTACK<=0.
//  WAIT/MFPW: to_cnt increments each edge; on edge where to_cnt==TIMEOUT-1 and no ack
//    condition -> ERR, BERR<=0. Ack condition on the same edge wins over timeout.
//  ACK/ERR: hold DTACK/BERR low until edge with AS=1 -> IDLE, DTACK<=1, BERR<=1.
//  Abort: AS=1 sampled in WAIT or MFPW -> IDLE, no DTACK/BERR issued.
//  DTACK and BERR never both low; after AS=1 both negated within 1 edge.
//  New cycle only accepted from IDLE: back-to-back cycles need AS high for >=1 sampled edge.
//  to_cnt saturates; never wraps. Enables changing mid-wait are ignored (latched at start).
//  Reset asserted mid-cycle: outputs negate immediately (async), FSM to IDLE.
//  BUSY = (state != IDLE), registered with state.
// TESTING
//  ROM read, ROM_WS=2: AS=0,ROMEN=0 at edge 0 -> DTACK low after edge 3; AS=1 at edge 5
//    -> DTACK high after edge 5, BUSY=0.
//  RAM read, RAM_WS=0: AS=0,RAMEN0=0 at edge 0 -> DTACK low after edge 1; BERR stays 1.
//  MFP: MFPEN=0 with AS=1 for 10 cycles -> FSM stays IDLE; then AS=0, MFP_DTACK low at
//    cycle 5 -> DTACK low 3 edges later (2 sync + 1 FSM); released when AS=1.
//  Unmapped: AS=0, all enables 1 -> BERR low after edge TIMEOUT (64), DTACK never low;
//    AS=1 -> BERR high next edge.
//  Abort/reset: AS=0,ROMEN=0 then AS=1 at edge 1 -> no DTACK, IDLE at edge 2; repeat and
//    pull RST low mid-wait -> DTACK=BERR=1, BUSY=0 without a clock edge.

Source files
------------

// File: rtl/mackerel_dtack_gen.sv
// mackerel_dtack_gen: 68000 bus-cycle terminator.
// Sits behind the address decoder. It inserts per-device wait states before it drives
// DTACK, passes the MC68901's own DTACK through, and raises BERR when nothing answers
// before the timeout.
// Ports:
//   CLK        CPU clock; all state changes on the rising edge
//   RST        asynchronous reset, active low
//   AS         68000 address strobe, active low
//   ROMEN      ROM select, active low, already qualified by AS
//   RAMEN0     RAM bank 0 select, active low, already qualified by AS
//   MFPEN      MFP select, active low, not qualified by AS (gated here)
//   MFP_DTACK  MC68901 DTACK, active low, asynchronous to CLK
//   DTACK      DTACK to the CPU, active low, registered
//   BERR       BERR to the CPU, active low, registered
//   BUSY       high while a bus cycle is being tracked, registered
module mackerel_dtack_gen #(
   parameter int unsigned ROM_WS  = 2,
   parameter int unsigned RAM_WS  = 0,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TO_W    = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic AS,
   input  logic ROMEN,
   input  logic RAMEN0,
   input  logic MFPEN,
   input  logic MFP_DTACK,
   output logic DTACK,
   output logic BERR,
   output logic BUSY
);

   localparam int unsigned WS_W = 4;
   localparam logic [WS_W-1:0] ROM_WS_V = WS_W'(ROM_WS);
   localparam logic [WS_W-1:0] RAM_WS_V = WS_W'(RAM_WS);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_MFPW = 3'd2,
      S_ACK  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [WS_W-1:0] ws_cnt, ws_nxt;
   logic [TO_W-1:0] to_cnt, to_nxt, to_inc;
   logic            nomatch, nomatch_nxt;
   logic            timeout_hit;
   logic            mdt_m, mdt_s;
   logic            dtack_nxt, berr_nxt, busy_nxt;

   // Two-flop synchronizer for the MFP's DTACK; it idles high.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mdt_m <= 1'b1;
         mdt_s <= 1'b1;
      end else begin
         mdt_m <= MFP_DTACK;
         mdt_s <= mdt_m;
      end
   end

   // State register together with the counters and the registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= S_IDLE;
         ws_cnt  <= '0;
         to_cnt  <= '0;
         nomatch <= 1'b0;
         DTACK   <= 1'b1;
         BERR    <= 1'b1;
         BUSY    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ws_cnt  <= ws_nxt;
         to_cnt  <= to_nxt;
         nomatch <= nomatch_nxt;
         DTACK   <= dtack_nxt;
         BERR    <= berr_nxt;
         BUSY    <= busy_nxt;
      end
   end

   // The timeout counter saturates so that it can never wrap back into range.
   assign to_inc      = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
   assign timeout_hit = (to_cnt == TO_LAST);

   // Next-state logic. The device selects are latched only at the start of a cycle.
   // An AS that has gone high ends any cycle that is still pending.
   always_comb begin
      state_nxt   = state;
      ws_nxt      = ws_cnt;
      to_nxt      = to_cnt;
      nomatch_nxt = nomatch;
      case (state)
         S_IDLE: begin
            if (!AS) begin
               to_nxt      = '0;
               ws_nxt      = '0;
               nomatch_nxt = 1'b0;
               if (!ROMEN) begin
                  state_nxt = S_WAIT;
                  ws_nxt    = ROM_WS_V;
               end else if (!RAMEN0) begin
                  state_nxt = S_WAIT;
                  ws_nxt    = RAM_WS_V;
               end else if (!MFPEN) begin
                  state_nxt = S_MFPW;
               end else begin
                  // Unmapped access: wait with no device, so only the timeout can end it.
                  state_nxt   = S_WAIT;
                  nomatch_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (AS) begin
               state_nxt = S_IDLE;
            end else begin
               to_nxt = to_inc;
               if (!nomatch && (ws_cnt == '0)) begin
                  state_nxt = S_ACK;
               end else if (timeout_hit) begin
                  state_nxt = S_ERR;
               end else if (!nomatch) begin
                  ws_nxt = ws_cnt - WS_W'(1);
               end
            end
         end
         S_MFPW: begin
            if (AS) begin
               state_nxt = S_IDLE;
            end else begin
               to_nxt = to_inc;
               if (!mdt_s) begin
                  state_nxt = S_ACK;
               end else if (timeout_hit) begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_ACK, S_ERR: begin
            if (AS) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode, taken from the next state so that the outputs can be registered.
   always_comb begin
      dtack_nxt = 1'b1;
      berr_nxt  = 1'b1;
      busy_nxt  = 1'b0;
      if (state_nxt == S_ACK)  dtack_nxt = 1'b0;
      if (state_nxt == S_ERR)  berr_nxt  = 1'b0;
      if (state_nxt != S_IDLE) busy_nxt  = 1'b1;
   end

endmodule
